// File: rtl/adv7513_config_seq.sv
// ADV7513 bring-up sequencer: waits out power-up, then writes the register table through a byte-level I2C master.
// Build option ADV7513_HPD_REINIT_EN: re-runs the table, prefixed by an interrupt clear, on an HDMI_TX_INT falling edge.
module adv7513_config_seq #(
  parameter int unsigned POWERUP_CYCLES   = 10000000,
  parameter int unsigned RETRY_GAP_CYCLES = 50000,
  parameter int unsigned MAX_RETRIES      = 3,
  parameter logic [6:0]  DEV_ADDR         = 7'h39
) (
  input  logic       CLK_50MHZ,
  input  logic       RESET_N,
  input  logic       HDMI_TX_INT,
  output logic       CMD_VALID,
  input  logic       CMD_READY,
  output logic [6:0] CMD_DEV,
  output logic [7:0] CMD_REG,
  output logic [7:0] CMD_DATA,
  input  logic       RSP_VALID,
  input  logic       RSP_NACK,
  output logic       CONFIG_DONE,
  output logic       CONFIG_ERROR,
  output logic [3:0] ENTRY_IDX
);

  localparam int unsigned PWR_W = (POWERUP_CYCLES > 32'd0) ? $clog2(POWERUP_CYCLES + 32'd1) : 1;
  localparam int unsigned GAP_W = (RETRY_GAP_CYCLES > 32'd0) ? $clog2(RETRY_GAP_CYCLES + 32'd1) : 1;
  localparam int unsigned CNT_W = (PWR_W > GAP_W) ? PWR_W : GAP_W;
  localparam int unsigned RTY_W = (MAX_RETRIES > 32'd0) ? $clog2(MAX_RETRIES + 32'd1) : 1;

  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWERUP_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(RETRY_GAP_CYCLES - 32'd1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

`ifdef ADV7513_HPD_REINIT_EN
  localparam logic [3:0] LAST_IDX = 4'd11;
`else
  localparam logic [3:0] LAST_IDX = 4'd10;
`endif

  typedef enum logic [2:0] {
    ST_WAIT_PWR = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT_RSP = 3'd2,
    ST_BACKOFF  = 3'd3,
    ST_DONE     = 3'd4,
    ST_ERROR    = 3'd5
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [RTY_W-1:0] retry_cnt_r;
  logic             cmd_valid_r;
  logic [7:0]       cmd_reg_r;
  logic [7:0]       cmd_data_r;
  logic             config_done_r;
  logic             config_error_r;
  logic [3:0]       entry_idx_r;

  logic             pwr_end_s;
  logic             gap_end_s;
  logic             int_fall_s;
  logic [3:0]       entry_inc_s;

  // Register table as {reg, data}; the interrupt-clear write is prepended when re-init is built in.
  function automatic logic [15:0] table_entry(input logic [3:0] idx);
    logic [3:0]  base;
    logic [15:0] e;
`ifdef ADV7513_HPD_REINIT_EN
    base = idx - 4'd1;
`else
    base = idx;
`endif
    case (base)
      4'd0:    e = 16'h4110;
      4'd1:    e = 16'h9803;
      4'd2:    e = 16'h9AE0;
      4'd3:    e = 16'h9C30;
      4'd4:    e = 16'h9D61;
      4'd5:    e = 16'hA2A4;
      4'd6:    e = 16'hA3A4;
      4'd7:    e = 16'hE0D0;
      4'd8:    e = 16'hF900;
      4'd9:    e = 16'h1500;
      4'd10:   e = 16'h1630;
      default: e = 16'h0000;
    endcase
`ifdef ADV7513_HPD_REINIT_EN
    if (idx == 4'd0) begin
      e = 16'h96C0;
    end else begin
      e = e;
    end
`endif
    return e;
  endfunction

`ifdef ADV7513_HPD_REINIT_EN
  logic int_meta_r;
  logic int_sync_r;
  logic int_prev_r;

  // Two-flop synchroniser for the asynchronous interrupt plus a delay stage for edge detection.
  always_ff @(posedge CLK_50MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      int_meta_r <= 1'b1;
      int_sync_r <= 1'b1;
      int_prev_r <= 1'b1;
    end else begin
      int_meta_r <= HDMI_TX_INT;
      int_sync_r <= int_meta_r;
      int_prev_r <= int_sync_r;
    end
  end

  assign int_fall_s = int_prev_r & ~int_sync_r;
`else
  logic unused_int_s;
  assign unused_int_s = HDMI_TX_INT;
  assign int_fall_s   = 1'b0;
`endif

  assign pwr_end_s   = (POWERUP_CYCLES == 32'd0) || (cnt_r == PWR_LAST);
  assign gap_end_s   = (RETRY_GAP_CYCLES == 32'd0) || (cnt_r == GAP_LAST);
  assign entry_inc_s = entry_idx_r + 4'd1;

  // Sequencer: every output, including the command payload, is registered as a state enters.
  always_ff @(posedge CLK_50MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r        <= ST_WAIT_PWR;
      cnt_r          <= {CNT_W{1'b0}};
      retry_cnt_r    <= {RTY_W{1'b0}};
      cmd_valid_r    <= 1'b0;
      cmd_reg_r      <= 8'h00;
      cmd_data_r     <= 8'h00;
      config_done_r  <= 1'b0;
      config_error_r <= 1'b0;
      entry_idx_r    <= 4'd0;
    end else begin
      case (state_r)
        ST_WAIT_PWR: begin
          if (pwr_end_s) begin
            state_r                 <= ST_ISSUE;
            cnt_r                   <= {CNT_W{1'b0}};
            cmd_valid_r             <= 1'b1;
            {cmd_reg_r, cmd_data_r} <= table_entry(entry_idx_r);
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_ISSUE: begin
          if (CMD_READY) begin
            state_r     <= ST_WAIT_RSP;
            cmd_valid_r <= 1'b0;
          end else begin
            cmd_valid_r <= 1'b1;
          end
        end
        ST_WAIT_RSP: begin
          if (RSP_VALID && !RSP_NACK) begin
            if (entry_idx_r == LAST_IDX) begin
              state_r       <= ST_DONE;
              config_done_r <= 1'b1;
            end else begin
              state_r                 <= ST_ISSUE;
              entry_idx_r             <= entry_inc_s;
              retry_cnt_r             <= {RTY_W{1'b0}};
              cmd_valid_r             <= 1'b1;
              {cmd_reg_r, cmd_data_r} <= table_entry(entry_inc_s);
            end
          end else if (RSP_VALID && RSP_NACK) begin
            if (retry_cnt_r < RTY_MAX) begin
              state_r     <= ST_BACKOFF;
              retry_cnt_r <= retry_cnt_r + RTY_W'(1);
              cnt_r       <= {CNT_W{1'b0}};
            end else begin
              state_r        <= ST_ERROR;
              config_error_r <= 1'b1;
            end
          end else begin
            state_r <= ST_WAIT_RSP;
          end
        end
        ST_BACKOFF: begin
          // Payload registers still hold the NACKed entry, so the retry reuses them.
          if (gap_end_s) begin
            state_r     <= ST_ISSUE;
            cnt_r       <= {CNT_W{1'b0}};
            cmd_valid_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_DONE, ST_ERROR: begin
          if (int_fall_s) begin
            state_r                 <= ST_ISSUE;
            config_done_r           <= 1'b0;
            config_error_r          <= 1'b0;
            entry_idx_r             <= 4'd0;
            retry_cnt_r             <= {RTY_W{1'b0}};
            cmd_valid_r             <= 1'b1;
            {cmd_reg_r, cmd_data_r} <= table_entry(4'd0);
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          state_r     <= ST_WAIT_PWR;
          cnt_r       <= {CNT_W{1'b0}};
          cmd_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign CMD_VALID    = cmd_valid_r;
  assign CMD_DEV      = DEV_ADDR;
  assign CMD_REG      = cmd_reg_r;
  assign CMD_DATA     = cmd_data_r;
  assign CONFIG_DONE  = config_done_r;
  assign CONFIG_ERROR = config_error_r;
  assign ENTRY_IDX    = entry_idx_r;

endmodule

// File: tb/tb_adv7513_config_seq.sv
// Randomised bench for adv7513_config_seq: the bench plays the I2C master and
// predicts the write stream from the table and a per-entry NACK plan.
module tb_adv7513_config_seq;
  localparam int PWR    = 20;
  localparam int GAP    = 8;
  localparam int MAXR   = 3;
  localparam int BUDGET = 400;
`ifdef ADV7513_HPD_REINIT_EN
  localparam int NENT = 12;
`else
  localparam int NENT = 11;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       int_n = 1'b1;
  logic       cmd_valid, cmd_ready = 1'b0;
  logic [6:0] cmd_dev;
  logic [7:0] cmd_reg, cmd_data;
  logic       rsp_valid = 1'b0, rsp_nack = 1'b0;
  logic       cfg_done, cfg_err;
  logic [3:0] entry_idx;

  adv7513_config_seq #(
    .POWERUP_CYCLES(PWR), .RETRY_GAP_CYCLES(GAP), .MAX_RETRIES(MAXR), .DEV_ADDR(7'h39)
  ) dut (
    .CLK_50MHZ(clk), .RESET_N(rst_n), .HDMI_TX_INT(int_n),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_DEV(cmd_dev),
    .CMD_REG(cmd_reg), .CMD_DATA(cmd_data), .RSP_VALID(rsp_valid), .RSP_NACK(rsp_nack),
    .CONFIG_DONE(cfg_done), .CONFIG_ERROR(cfg_err), .ENTRY_IDX(entry_idx)
  );

  always #5 clk = ~clk;

  int pcyc = 0;
  int xfer_cnt = 0;
  always @(posedge clk) pcyc <= pcyc + 1;
  always @(posedge clk) if (rst_n && cmd_valid && cmd_ready) xfer_cnt <= xfer_cnt + 1;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: table contents and the write stream implied by a NACK plan.
  logic [15:0] tbl [NENT];
  int          nack_plan [16];
  logic [15:0] exp_q [$];
  bit          exp_err;
  int          exp_idx;
  int          nxfer;

  function automatic void clear_plan();
    for (int i = 0; i < 16; i++) nack_plan[i] = 0;
  endfunction

  function automatic void build_model();
    int att;
    exp_q.delete();
    exp_err = 1'b0;
    exp_idx = 0;
    for (int i = 0; i < NENT; i++) begin
      att = (nack_plan[i] > MAXR) ? MAXR + 1 : nack_plan[i] + 1;
      for (int a = 0; a < att; a++) exp_q.push_back(tbl[i]);
      exp_idx = i;
      if (nack_plan[i] > MAXR) begin
        exp_err = 1'b1;
        break;
      end
    end
    nxfer = exp_q.size();
  endfunction

  task automatic do_reset();
    int n;
    @(negedge clk);
    rst_n = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_nack = 1'b0; int_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", {cmd_valid, cmd_reg, cmd_data, cfg_done, cfg_err, entry_idx}, 32'd0);
    rst_n = 1'b1;
    n = 0;
    while (cmd_valid !== 1'b1 && n < BUDGET) begin
      cmd_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    cmd_ready = 1'b0;
    check_eq("first_valid_cycle", n, PWR);
  endtask

  // Acts as the I2C master for one pass of the table and compares against the model.
  task automatic run_seq(input int abort_at, input int stall_entry, input int stall_len, input int int_entry);
    int cur, nsent, n, k, last_rsp, xbase;
    bit last_nack, first;
    logic [15:0] e;
    build_model();
    xbase = xfer_cnt;
    cur = 0; nsent = 0; first = 1'b1; last_nack = 1'b0; last_rsp = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = 0;
      while (cmd_valid !== 1'b1 && n < BUDGET) begin
        cmd_ready = 1'($urandom_range(0, 1));
        rsp_valid = 1'($urandom_range(0, 1));
        @(negedge clk);
        n++;
      end
      rsp_valid = 1'b0;
      if (cmd_valid !== 1'b1) begin
        check_eq("cmd_valid_timeout", {31'd0, cmd_valid}, 32'd1);
        return;
      end
      if (!first) begin
        if (last_nack) check_eq("backoff_gap", pcyc - last_rsp, GAP + 1);
        else           check_eq("ack_to_issue", pcyc - last_rsp, 1);
      end
      k = (cur == stall_entry) ? stall_len : $urandom_range(0, 2);
      cmd_ready = 1'b0;
      for (int s = 0; s < k; s++) begin
        rsp_valid = 1'($urandom_range(0, 1));
        rsp_nack  = 1'($urandom_range(0, 1));
        @(negedge clk);
        check_eq("stall_valid", {31'd0, cmd_valid}, 32'd1);
        check_eq("stall_payload", {cmd_reg, cmd_data}, e);
      end
      rsp_valid = 1'b0; rsp_nack = 1'b0;
      cmd_ready = 1'b1;
      check_eq("cmd_payload", {cmd_dev, cmd_reg, cmd_data}, {7'h39, e});
      @(negedge clk);
      cmd_ready = 1'($urandom_range(0, 1));
      check_eq("valid_drop", {31'd0, cmd_valid}, 32'd0);
      if (cur == abort_at) begin
        #2 rst_n = 1'b0;
        #1 check_eq("async_reset", {cmd_valid, cmd_reg, cmd_data, cfg_done, cfg_err, entry_idx}, 32'd0);
        return;
      end
      if (cur == int_entry) int_n = 1'b0;
      repeat ($urandom_range(0, 4)) @(negedge clk);
      rsp_nack  = (nsent < nack_plan[cur]);
      rsp_valid = 1'b1;
      last_nack = rsp_nack;
      last_rsp  = pcyc;
      @(negedge clk);
      rsp_valid = 1'b0; rsp_nack = 1'b0; int_n = 1'b1; cmd_ready = 1'b0;
      if (last_nack) nsent++;
      else begin
        cur++;
        nsent = 0;
      end
      first = 1'b0;
    end
    repeat (2) @(negedge clk);
    check_eq("config_done", {31'd0, cfg_done}, {31'd0, !exp_err});
    check_eq("config_error", {31'd0, cfg_err}, {31'd0, exp_err});
    check_eq("entry_idx", entry_idx, exp_idx);
    check_eq("xfer_count", xfer_cnt - xbase, nxfer);
    n = 0;
    repeat (30) begin
      cmd_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (cmd_valid) n++;
    end
    cmd_ready = 1'b0;
    check_eq("quiet_after_end", n, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
`ifdef ADV7513_HPD_REINIT_EN
    tbl = '{16'h96C0, 16'h4110, 16'h9803, 16'h9AE0, 16'h9C30, 16'h9D61,
            16'hA2A4, 16'hA3A4, 16'hE0D0, 16'hF900, 16'h1500, 16'h1630};
`else
    tbl = '{16'h4110, 16'h9803, 16'h9AE0, 16'h9C30, 16'h9D61,
            16'hA2A4, 16'hA3A4, 16'hE0D0, 16'hF900, 16'h1500, 16'h1630};
`endif
    do_reset();
    clear_plan();
    run_seq(-1, 2, 5, 2);

`ifdef ADV7513_HPD_REINIT_EN
    @(negedge clk);
    int_n = 1'b0;
    n = 0;
    while (cmd_valid !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    check_eq("hpd_latency", {31'd0, n <= 4}, 32'd1);
    check_eq("hpd_done_clear", {31'd0, cfg_done}, 32'd0);
    int_n = 1'b1;
    clear_plan();
    run_seq(-1, -1, 0, 3);
`else
    @(negedge clk);
    int_n = 1'b0;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (cmd_valid || !cfg_done) n++;
    end
    int_n = 1'b1;
    check_eq("int_ignored", n, 0);
`endif

    do_reset(); clear_plan(); nack_plan[4] = 2; run_seq(-1, -1, 0, -1);
    do_reset(); clear_plan(); nack_plan[3] = 4; run_seq(-1, -1, 0, -1);
    do_reset(); clear_plan(); run_seq(6, -1, 0, -1);

    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int i = 0; i < 16; i++)
        nack_plan[i] = ($urandom_range(0, 15) == 0) ? MAXR + 1 : $urandom_range(0, 1);
      run_seq(-1, $urandom_range(0, NENT - 1), $urandom_range(1, 4), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/adv7513_config_seq.md
Name: adv7513_config_seq

Overview:
- Sequences the HDMI transmitter (ADV7513) register configuration over a separate byte-level I2C write master.
- Waits out the transmitter power-up time, then walks an internal table of register writes, issuing one write per command handshake.
- Retries NACKed writes and reports done or error status to the top level.
- Optionally re-runs the whole sequence on a hot-plug interrupt from HDMI_TX_INT.

Parameters:
- POWERUP_CYCLES, 10000000, idle cycles after reset before the first write (200 ms at 50 MHz); counter width is $clog2(POWERUP_CYCLES+1).
- RETRY_GAP_CYCLES, 50000, idle cycles between a NACK and the retry of the same entry.
- MAX_RETRIES, 3, retries allowed per entry after its first attempt.
- DEV_ADDR, 7'h39, 7-bit I2C device address driven on every command.

Ports:
- CLK_50MHZ  input  1  clock.
- RESET_N  input  1  asynchronous, active-low reset.
- HDMI_TX_INT  input  1  transmitter interrupt, active-low, asynchronous to CLK_50MHZ.
- CMD_VALID  output  1  write command valid.
- CMD_READY  input  1  I2C master accepts the command.
- CMD_DEV  output  7  device address (= DEV_ADDR).
- CMD_REG  output  8  register address.
- CMD_DATA  output  8  register data.
- RSP_VALID  input  1  one-cycle pulse: transaction finished.
- RSP_NACK  input  1  qualified by RSP_VALID; 1 = NACK received.
- CONFIG_DONE  output  1  level: table fully written.
- CONFIG_ERROR  output  1  level: an entry exhausted its retries.
- ENTRY_IDX  output  4  index of the current or last table entry (debug).

Behaviour:
- Reset (async assert, sync release): state WAIT_PWR, counter=0, CMD_VALID=0, CMD_REG=0, CMD_DATA=0, CONFIG_DONE=0, CONFIG_ERROR=0, ENTRY_IDX=0, retry count=0.
- Table: 11 entries, index 0..10, as {reg,data}:
  - 41/10, 98/03, 9A/E0, 9C/30, 9D/61, A2/A4, A3/A4, E0/D0, F9/00, 15/00, 16/30.
  - Combinational ROM indexed by ENTRY_IDX.
- WAIT_PWR:
  - Count up to POWERUP_CYCLES-1, then go to ISSUE.
  - With POWERUP_CYCLES=0, go to ISSUE on the first cycle after reset.
- ISSUE:
  - CMD_VALID=1; CMD_REG and CMD_DATA come from the table and are registered on entry.
  - Payload stays stable while CMD_VALID=1 and CMD_READY=0.
  - Transfer happens on the cycle with CMD_VALID & CMD_READY; next cycle CMD_VALID=0 and state is WAIT_RSP.
- WAIT_RSP:
  - RSP_VALID & !RSP_NACK:
    - If ENTRY_IDX=10, go to DONE.
    - Otherwise ENTRY_IDX+1, retry count cleared, go to ISSUE.
  - RSP_VALID & RSP_NACK:
    - If retry count < MAX_RETRIES, retry count+1 and go to BACKOFF.
    - Otherwise go to ERROR.
- BACKOFF: wait RSP_GAP_CYCLES — i.e. RETRY_GAP_CYCLES — cycles, then ISSUE the same entry.
- DONE: CONFIG_DONE=1; ENTRY_IDX holds 10.
- ERROR: CONFIG_ERROR=1; ENTRY_IDX holds the failing index. Exit only by reset (or re-init, see the optional feature).
- RSP_VALID in any state other than WAIT_RSP is ignored.
- CMD_READY while CMD_VALID=0 has no effect.
- Reset mid-transaction: state returns to WAIT_PWR immediately; the I2C master is reset by the same reset.
- Latency, zero-wait master: one write costs 1 cycle ISSUE + the response wait. The first CMD_VALID rises at cycle POWERUP_CYCLES after reset release.

Optional Feature:
- Macro: ADV7513_HPD_REINIT_EN.
- Defined:
  - HDMI_TX_INT goes through a 2-FF synchroniser; a falling edge is detected on the synchronised signal.
  - In DONE or ERROR, a falling edge clears CONFIG_DONE, CONFIG_ERROR, ENTRY_IDX and retry count, then enters ISSUE. There is no power-up wait on re-init.
  - Falling edges in any other state are dropped.
  - The table gains a 12th entry, 96/C0 (clear interrupts), written first; ENTRY_IDX for the last entry becomes 11.
- Not defined: HDMI_TX_INT is unused, the table is 11 entries, and DONE/ERROR are terminal.

Test Plan:
- POWERUP_CYCLES=20, CMD_READY=1, ack every command 3 cycles later: first CMD_VALID at cycle 20 with REG=41, DATA=10. All 11 entries issue in table order. CONFIG_DONE=1 after the RSP for 16/30, and ENTRY_IDX=10.
- CMD_READY held low 5 cycles during entry 2: CMD_VALID stays 1 with REG=9A, DATA=E0 stable throughout. Exactly one transfer is counted.
- NACK on entry 4 twice, then ACK, with RETRY_GAP_CYCLES=8: 9D/61 is issued 3 times, with ≥8 idle cycles between issues. The sequence then completes with CONFIG_ERROR=0.
- NACK on entry 3 four times, MAX_RETRIES=3: 4 attempts of 9C/30, then CONFIG_ERROR=1, ENTRY_IDX=3, and no further CMD_VALID.
- Assert RESET_N=0 during WAIT_RSP of entry 6: all outputs return to reset values asynchronously. After release the sequence restarts from entry 0 after POWERUP_CYCLES.
- ADV7513_HPD_REINIT_EN, after CONFIG_DONE pull HDMI_TX_INT low: within 4 cycles CONFIG_DONE=0 and CMD_VALID=1 with REG=96, DATA=C0. The full 12-entry table rewrites. An INT edge during WAIT_RSP causes no restart.
